// File: rtl/pe_sequencer_if.sv
// Bus bundle between the PE sequencer and its environment: weight/activation
// streams, the result stream, and the PE's weight-load and compute ports.
interface pe_sequencer_if #(
  parameter int weight_bit = 32,
  parameter int depth      = 16,
  parameter int len_w      = $clog2(depth) + 1
);
  localparam int addr_w = $clog2(depth);

  logic [len_w-1:0]      cfg_len;
  logic                  w_valid;
  logic                  w_ready;
  logic [weight_bit-1:0] w_data;
  logic                  x_valid;
  logic                  x_ready;
  logic [weight_bit-1:0] x_data;
  logic                  res_valid;
  logic                  res_ready;
  logic [weight_bit-1:0] res_data;
  logic                  pe_demux_select;
  logic                  pe_mux_select;
  logic                  pe_write_enable;
  logic                  pe_read_enable;
  logic [addr_w-1:0]     pe_wr_addr;
  logic [addr_w-1:0]     pe_rd_addr;
  logic [weight_bit-1:0] pe_weight;
  logic [weight_bit-1:0] pe_input_data;
  logic                  pe_acc_clear;
  logic [weight_bit-1:0] pe_out;

  // Sequencer side.
  modport master (
    input  cfg_len, w_valid, w_data, x_valid, x_data, res_ready, pe_out,
    output w_ready, x_ready, res_valid, res_data,
           pe_demux_select, pe_mux_select, pe_write_enable, pe_read_enable,
           pe_wr_addr, pe_rd_addr, pe_weight, pe_input_data, pe_acc_clear
  );

  // Environment side: stream producers/consumer and the PE itself.
  modport slave (
    output cfg_len, w_valid, w_data, x_valid, x_data, res_ready, pe_out,
    input  w_ready, x_ready, res_valid, res_data,
           pe_demux_select, pe_mux_select, pe_write_enable, pe_read_enable,
           pe_wr_addr, pe_rd_addr, pe_weight, pe_input_data, pe_acc_clear
  );
endinterface

// File: rtl/pe_sequencer.sv
// Ping-pong weight loader plus compute FSM driving an MLP processing element;
// loading one bank overlaps with a dot product on the other.
module pe_sequencer #(
  parameter int weight_bit = 32,
  parameter int depth      = 16,
  parameter int len_w      = $clog2(depth) + 1
) (
  input  logic          clk,
  input  logic          reset,
  pe_sequencer_if.master bus
);
  localparam int addr_w = $clog2(depth);
  localparam logic [len_w-1:0] depth_len = len_w'(depth);

  typedef enum logic [2:0] {IDLE, CLEAR, MAC, CAPTURE, OUT} state_t;

  state_t                state;
  state_t                state_next;

  logic [1:0]            bank_valid;
  logic                  wbank;
  logic                  cbank;
  logic [len_w-1:0]      len_q [2];
  logic [addr_w-1:0]     wcnt;
  logic [addr_w-1:0]     xcnt;
  logic [addr_w-1:0]     rd_addr_q;
  logic [weight_bit-1:0] res_data_q;
  logic                  res_valid_q;

  logic [len_w-1:0]      eff_len;
  logic [len_w-1:0]      wlen;
  logic [len_w-1:0]      clen;
  logic                  w_ready_int;
  logic                  w_fire;
  logic                  w_last;
  logic                  x_fire;
  logic                  x_last;
  logic                  capture;

  logic                  x_ready_c;
  logic                  read_c;
  logic                  clear_c;
  logic [weight_bit-1:0] input_c;
  logic [addr_w-1:0]     rd_addr_c;

  // Until the first beat latches the length, the live cfg_len governs the bank.
  always_comb begin
    eff_len = bus.cfg_len;
    if (bus.cfg_len == '0 || bus.cfg_len > depth_len) begin
      eff_len = depth_len;
    end
    wlen = (wcnt == '0) ? eff_len : len_q[wbank];
    clen = len_q[cbank];
  end

  assign w_ready_int = !reset && !bank_valid[wbank];
  assign w_fire      = bus.w_valid && w_ready_int;
  assign w_last      = (len_w'(wcnt) == (wlen - len_w'(1)));
  assign x_fire      = !reset && (state == MAC) && bus.x_valid;
  assign x_last      = (len_w'(xcnt) == (clen - len_w'(1)));
  assign capture     = (state == CAPTURE);

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt     <= '0;
      wbank    <= 1'b0;
      len_q[0] <= '0;
      len_q[1] <= '0;
    end else if (w_fire) begin
      if (wcnt == '0) begin
        len_q[wbank] <= eff_len;
      end
      if (w_last) begin
        wcnt  <= '0;
        wbank <= ~wbank;
      end else begin
        wcnt <= wcnt + addr_w'(1);
      end
    end
  end

  // Load and compute always address opposite banks, so set and clear never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_valid <= 2'b00;
    end else begin
      if (w_fire && w_last) begin
        bank_valid[wbank] <= 1'b1;
      end
      if (capture) begin
        bank_valid[cbank] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    x_ready_c  = 1'b0;
    read_c     = 1'b0;
    clear_c    = 1'b0;
    input_c    = '0;
    rd_addr_c  = rd_addr_q;
    case (state)
      IDLE: begin
        if (bank_valid[cbank]) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        clear_c    = 1'b1;
        state_next = MAC;
      end
      MAC: begin
        x_ready_c = 1'b1;
        read_c    = 1'b1;
        if (bus.x_valid) begin
          input_c = bus.x_data;
          if (x_last) begin
            state_next = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        read_c     = 1'b1;
        rd_addr_c  = addr_w'(clen - len_w'(1));
        state_next = OUT;
      end
      OUT: begin
        if (bus.res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // rd_addr_q trails the accepted beat by one cycle to meet the PE's input register.
  always_ff @(posedge clk) begin
    if (reset) begin
      xcnt        <= '0;
      rd_addr_q   <= '0;
      cbank       <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          xcnt      <= '0;
          rd_addr_q <= '0;
        end
        MAC: begin
          if (x_fire) begin
            rd_addr_q <= xcnt;
            xcnt      <= x_last ? '0 : xcnt + addr_w'(1);
          end
        end
        CAPTURE: begin
          res_data_q  <= bus.pe_out;
          res_valid_q <= 1'b1;
          cbank       <= ~cbank;
        end
        OUT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.w_ready         = w_ready_int;
  assign bus.x_ready         = x_ready_c && !reset;
  assign bus.res_valid       = res_valid_q;
  assign bus.res_data        = res_data_q;
  assign bus.pe_demux_select = wbank;
  assign bus.pe_mux_select   = cbank;
  assign bus.pe_write_enable = w_fire;
  assign bus.pe_read_enable  = read_c && !reset;
  assign bus.pe_wr_addr      = wcnt;
  assign bus.pe_rd_addr      = rd_addr_c;
  assign bus.pe_weight       = bus.w_data;
  assign bus.pe_input_data   = reset ? '0 : input_c;
  assign bus.pe_acc_clear    = reset || clear_c;
endmodule
